// File: rtl/cplx_div_seq.sv
// Sequenced complex divider: op = in1 / in2 on packed {re, im} 24-bit FP words,
// using time-shared mul/mul/addsub/div units. Define CPLX_DIV_ZCHK_EN to enable the zero-denominator bypass.
module cplx_div_seq #(
  parameter int UNIT_LAT = 1,
  parameter int WIDTH    = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op,
  output logic             dz
);
  localparam int HW = WIDTH / 2;
  localparam int CW = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;

  // FP word: sign[23], exp[22:16] bias 63, mantissa[15:0] with hidden one; exp 0 is zero.
  // All units truncate; overflow saturates to exp 7F / mantissa 0.
  function automatic logic [23:0] fp_mul(input logic [23:0] x, input logic [23:0] y);
    logic [33:0]       p;
    logic [17:0]       pp;
    logic [15:0]       m;
    logic signed [9:0] e;
    logic              s;
    s  = x[23] ^ y[23];
    p  = {17'd0, 1'b1, x[15:0]} * {17'd0, 1'b1, y[15:0]};
    pp = 18'(p >> 16);
    e  = $signed({3'd0, x[22:16]}) + $signed({3'd0, y[22:16]}) - 10'sd63;
    if (pp[17]) begin
      m = pp[16:1];
      e = e + 10'sd1;
    end else begin
      m = pp[15:0];
    end
    if (x[22:16] == 7'd0 || y[22:16] == 7'd0 || e <= 10'sd0) return 24'h0;
    if (e >= 10'sd127) return {s, 7'h7F, 16'h0};
    return {s, e[6:0], m};
  endfunction

  function automatic logic [23:0] fp_add(input logic [23:0] x, input logic [23:0] y,
                                         input logic sub);
    logic [23:0]       yy, big, sml;
    logic [16:0]       mb, ms, nrm;
    logic [17:0]       sum;
    logic [6:0]        sh;
    logic signed [9:0] e;
    yy = {y[23] ^ sub, y[22:0]};
    if (yy[22:16] == 7'd0) return (x[22:16] == 7'd0) ? 24'h0 : x;
    if (x[22:16] == 7'd0) return yy;
    if (x[22:0] >= yy[22:0]) begin
      big = x;
      sml = yy;
    end else begin
      big = yy;
      sml = x;
    end
    sh = big[22:16] - sml[22:16];
    mb = {1'b1, big[15:0]};
    ms = {1'b1, sml[15:0]} >> sh;
    e  = $signed({3'd0, big[22:16]});
    if (big[23] == sml[23]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[17]) begin
        nrm = sum[17:1];
        e   = e + 10'sd1;
      end else begin
        nrm = sum[16:0];
      end
    end else begin
      nrm = mb - ms;
      if (nrm == 17'd0) return 24'h0;
      for (int i = 0; i < 17; i++) begin
        if (!nrm[16]) begin
          nrm = nrm << 1;
          e   = e - 10'sd1;
        end
      end
    end
    if (e <= 10'sd0) return 24'h0;
    if (e >= 10'sd127) return {big[23], 7'h7F, 16'h0};
    return {big[23], e[6:0], nrm[15:0]};
  endfunction

  function automatic logic [23:0] fp_div(input logic [23:0] x, input logic [23:0] y);
    logic [33:0]       num, dv;
    logic [17:0]       q;
    logic [15:0]       m;
    logic signed [9:0] e;
    logic              s;
    s = x[23] ^ y[23];
    if (y[22:16] == 7'd0) return {s, 7'h7F, 16'h0};
    if (x[22:16] == 7'd0) return 24'h0;
    num = {1'b1, x[15:0], 17'd0};
    dv  = {17'd0, 1'b1, y[15:0]};
    q   = 18'(num / dv);
    e   = $signed({3'd0, x[22:16]}) - $signed({3'd0, y[22:16]}) + 10'sd63;
    if (q[17]) begin
      m = q[16:1];
    end else begin
      m = q[15:0];
      e = e - 10'sd1;
    end
    if (e <= 10'sd0) return 24'h0;
    if (e >= 10'sd127) return {s, 7'h7F, 16'h0};
    return {s, e[6:0], m};
  endfunction

  typedef enum logic [3:0] {
    IDLE, MUL_A, MUL_B, MUL_C, ADD_RE, ADD_IM, ADD_DEN, DIV_RE, DIV_IM, DONE
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          skip_div;

  logic [HW-1:0] a, b, c, d;
  logic [HW-1:0] ac, bd, bc, ad, cc, dd;
  logic [HW-1:0] nr, ni, den, re, im;

  logic [HW-1:0] m0x, m0y, m1x, m1y, ax, ay, nx, dy;
  logic          sub;
  logic [HW-1:0] m0_res, m1_res, add_res, div_res;

  assign last      = (cnt == CW'(UNIT_LAT - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign op        = {re, im};

`ifdef CPLX_DIV_ZCHK_EN
  assign skip_div = (add_res[22:16] == 7'd0);
`else
  assign skip_div = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Step counter: every arithmetic state lasts exactly UNIT_LAT cycles.
  always_ff @(posedge clock) begin
    if (!reset_n || last || state == IDLE || state == DONE) cnt <= '0;
    else                                                     cnt <= cnt + 1'b1;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = MUL_A;
      MUL_A:   if (last) nxt = MUL_B;
      MUL_B:   if (last) nxt = MUL_C;
      MUL_C:   if (last) nxt = ADD_RE;
      ADD_RE:  if (last) nxt = ADD_IM;
      ADD_IM:  if (last) nxt = ADD_DEN;
      ADD_DEN: if (last) nxt = skip_div ? DONE : DIV_RE;
      DIV_RE:  if (last) nxt = DIV_IM;
      DIV_IM:  if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand steering for the shared units; held constant across each step.
  always_comb begin
    m0x = a;  m0y = c;  m1x = b;  m1y = d;
    ax  = ac; ay  = bd; sub = 1'b0;
    nx  = nr; dy  = den;
    case (state)
      MUL_B:   begin m0x = b; m0y = c; m1x = a; m1y = d; end
      MUL_C:   begin m0x = c; m0y = c; m1x = d; m1y = d; end
      ADD_IM:  begin ax = bc; ay = ad; sub = 1'b1; end
      ADD_DEN: begin ax = cc; ay = dd; end
      DIV_IM:  nx = ni;
      default: ;
    endcase
  end

  assign m0_res  = fp_mul(m0x, m0y);
  assign m1_res  = fp_mul(m1x, m1y);
  assign add_res = fp_add(ax, ay, sub);
  assign div_res = fp_div(nx, dy);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a  <= '0; b  <= '0; c  <= '0; d  <= '0;
      ac <= '0; bd <= '0; bc <= '0; ad <= '0; cc <= '0; dd <= '0;
      nr <= '0; ni <= '0; den <= '0; re <= '0; im <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a <= in1[WIDTH-1:HW]; b <= in1[HW-1:0];
          c <= in2[WIDTH-1:HW]; d <= in2[HW-1:0];
        end
        MUL_A:   if (last) begin ac <= m0_res; bd <= m1_res; end
        MUL_B:   if (last) begin bc <= m0_res; ad <= m1_res; end
        MUL_C:   if (last) begin cc <= m0_res; dd <= m1_res; end
        ADD_RE:  if (last) nr <= add_res;
        ADD_IM:  if (last) ni <= add_res;
        ADD_DEN: if (last) begin
          den <= add_res;
          if (skip_div) begin
            re <= '0;
            im <= '0;
          end
        end
        DIV_RE:  if (last) re <= div_res;
        DIV_IM:  if (last) im <= div_res;
        default: ;
      endcase
    end
  end

`ifdef CPLX_DIV_ZCHK_EN
  logic dz_r;
  always_ff @(posedge clock) begin
    if (!reset_n)                     dz_r <= 1'b0;
    else if (state == IDLE && in_valid) dz_r <= 1'b0;
    else if (state == ADD_DEN && last)  dz_r <= skip_div;
  end
  assign dz = dz_r;
`else
  assign dz = 1'b0;
`endif

endmodule

// File: doc/cplx_div_seq.md
Name: cplx_div_seq

Overview:
- Sequenced complex divider, the inverse operation of the team's packed complex multiplier. Computes op = in1 / in2 on packed 48-bit complex operands: {real[47:24], imag[23:0]}, each half a 24-bit FP word.
- Sits beside the complex multiplier in the Jacobi rotation datapath, for the normalisation steps.
- Reuses the team's registered 24-bit FP units: two multipliers, one add/sub and one divider, time-shared under an FSM with a valid/ready handshake.

Parameters:
- UNIT_LAT, 1: clock cycles from operand presentation to registered result, for every FP unit.
- WIDTH, 48: packed complex width. Fixed at 48; any other value is unsupported.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept an operation.
- in1  in  48  dividend {a, b} = a + bi.
- in2  in  48  divisor {c, d} = c + di.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- op  out  48  quotient {re, im}.
- dz  out  1  zero-denominator flag, qualified by out_valid.

Behaviour:
- FP word format: sign[23], exp[22:16] (bias 63), mantissa[15:0]. Zero means exp == 0.
- Maths:
  - re = (ac + bd) / (c·c + d·d)
  - im = (bc − ad) / (c·c + d·d)
- Reset (reset_n low at a rising edge): FSM goes to IDLE. in_ready=1, out_valid=0, op=0, dz=0. All internal operand and partial registers are cleared. Reset mid-operation aborts the operation; no result is emitted.
- Accept: handshake edge is in_valid && in_ready. in1 and in2 are captured at that edge. in_ready is 1 only in IDLE.
- FSM states and transitions. Every step state lasts exactly UNIT_LAT cycles. Operands are held constant for the whole step; the result is registered on the last cycle of the step.
  - IDLE: go to MUL_A on accept.
  - MUL_A: mult0=a·c, mult1=b·d. Go to MUL_B.
  - MUL_B: mult0=b·c, mult1=a·d. Go to MUL_C.
  - MUL_C: mult0=c·c, mult1=d·d. Go to ADD_RE.
  - ADD_RE: nr = ac + bd. Go to ADD_IM.
  - ADD_IM: ni = bc − ad. Go to ADD_DEN.
  - ADD_DEN: den = cc + dd. Go to DIV_RE, or to DONE when the zero check fires (see Optional Feature).
  - DIV_RE: re = nr / den. Go to DIV_IM.
  - DIV_IM: im = ni / den. Go to DONE.
  - DONE: out_valid=1; op and dz are held stable. Go to IDLE on out_ready.
- Latency:
  - out_valid rises 8·UNIT_LAT cycles after the accept edge (8 with the default).
  - Back-pressure: while out_ready=0 the block stays in DONE with out_valid, op and dz unchanged.
  - When out_ready=1 on the first DONE cycle, out_valid is a 1-cycle pulse.
- Throughput: one operation in flight. The next accept is possible on the cycle after the DONE handshake, because in_ready goes to 1 in IDLE.
- in_valid while busy is ignored; it is neither captured nor queued.
- Rounding, denormal and special-value handling are those of the FP units; this block adds no adjustment.

Optional Feature:
- Macro: CPLX_DIV_ZCHK_EN.
- Defined:
  - At the end of ADD_DEN, if den exp == 0, the FSM skips both DIV states and goes straight to DONE.
  - In that case op=48'h0 and dz=1, and out_valid rises 6·UNIT_LAT cycles after accept.
  - Otherwise dz=0.
- Undefined:
  - No zero check: the divider always runs, and a zero denominator gives whatever the divider returns (inf/NaN).
  - dz is tied to 0.
  - Latency is always 8·UNIT_LAT.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release -> in_ready=1, out_valid=0, op=0, dz=0.
- Identity divide: in1=in2={24'h3F0000,24'h3F0000} ((1+i)/(1+i)), out_ready=1, UNIT_LAT=1 -> out_valid 8 cycles after accept, op={24'h3F0000,24'h000000}, dz=0.
- Pure-imaginary divisor: in1={24'h400000,24'h0} (2+0i), in2={24'h0,24'h3F0000} (0+1i) -> op={24'h000000,24'hC00000} (0−2i).
- Back-pressure and busy: hold out_ready=0 for 5 cycles after out_valid -> op stable and out_valid held. Assert in_valid while busy with different operands -> ignored, and the first result is unchanged.
- Zero divisor: in2=48'h0 with CPLX_DIV_ZCHK_EN -> out_valid after 6 cycles, op=0, dz=1. Without the macro -> out_valid after 8 cycles, dz=0.
- Reset mid-op: drop reset_n in MUL_C -> no out_valid, in_ready=1 next cycle. A fresh operation then completes correctly.
